// File: rtl/dnn_uart_pkg.sv
// Shared UART definitions: state encoding and default baud constants.
// Used by uart_rx_toggle and intended for reuse by the companion transmitter.
package dnn_uart_pkg;

   localparam int DEFAULT_BITWIDTH     = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_START     = 3'd1;
   localparam state_t ST_DATA      = 3'd2;
   localparam state_t ST_PARITY    = 3'd3;
   localparam state_t ST_STOP      = 3'd4;
   localparam state_t ST_WAIT_IDLE = 3'd5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets both flops so the output holds a known level out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: flops use <= so both stages sample the pre-edge values and form a true 2-stage chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_toggle.sv
// UART receiver whose isNewData output toggles once per correctly received frame.
// Define UART_RX_PARITY_EN to expect and check one even-parity bit after the data.
module uart_rx_toggle
   import dnn_uart_pkg::*;
#(
   parameter int BITWIDTH     = DEFAULT_BITWIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rxd,
   output logic [BITWIDTH-1:0] dataOut,
   output logic                isNewData,
   output logic                frameError
);

   localparam int CW  = $clog2(CLKS_PER_BIT) + 1;
   localparam int BCW = $clog2(BITWIDTH + 1);

   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BCW-1:0] BITS_LAST = BCW'(BITWIDTH - 1);

   logic rxd_s;

   // The idle line is high, so the synchronizer resets to 1 to avoid a false start.
   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk_i (clock),
      .rst_ni(reset),
      .d_i   (rxd),
      .q_o   (rxd_s)
   );

   state_t              state_q,   state_d;
   logic [CW-1:0]       cnt_q,     cnt_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [BITWIDTH-1:0] shift_q,   shift_d;
   logic [BITWIDTH-1:0] data_q,    data_d;
   logic                toggle_q,  toggle_d;
   logic                ferr_q,    ferr_d;
   logic                bit_done;
   logic                stop_ok;

   assign bit_done = (cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
   logic par_err_q, par_err_d;
   assign stop_ok = rxd_s & ~par_err_q;
`else
   assign stop_ok = rxd_s;
`endif

   always_comb begin
      // NOTE: every next-state signal gets a default here so no path infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      toggle_d  = toggle_q;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rxd_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (rxd_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               cnt_d     = '0;
               shift_d   = {rxd_s, shift_q[BITWIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) begin
               cnt_d     = '0;
               // Even parity: data ones plus the parity bit must come to an even count.
               par_err_d = (^shift_q) ^ rxd_s;
               state_d   = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               cnt_d = '0;
               if (stop_ok) begin
                  data_d   = shift_q;
                  toggle_d = ~toggle_q;
                  state_d  = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_IDLE: begin
            // Any low sample restarts the full bit of idle required before re-arming.
            if (!rxd_s) begin
               cnt_d = '0;
            end else if (bit_done) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         toggle_q  <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         toggle_q  <= toggle_d;
         ferr_q    <= ferr_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end
`endif

   assign dataOut    = data_q;
   assign isNewData  = toggle_q;
   assign frameError = ferr_q;

endmodule

// File: tb/tb_uart_rx_toggle.sv
// Directed bench for uart_rx_toggle at CLKS_PER_BIT=16, BITWIDTH=8.
// The parity scenario is exercised only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_toggle;
   import dnn_uart_pkg::*;

   localparam int CPB = 16;
   localparam int BW  = 8;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = BW + 2;
`else
   localparam int NBITS = BW + 1;
`endif
   localparam int EXP_LAT = 2 + CPB / 2 + NBITS * CPB;

   logic          clock;
   logic          reset;
   logic          rxd;
   logic [BW-1:0] dataOut;
   logic          isNewData;
   logic          frameError;

   int n_checks = 0;
   int n_errors = 0;

   int            cyc        = 0;
   int            n_toggles  = 0;
   int            n_ferr     = 0;
   int            toggle_cyc = 0;
   int            start_cyc  = 0;
   logic          prev_new   = 1'b0;
   logic [BW-1:0] rx_q[$];

   uart_rx_toggle #(
      .BITWIDTH    (BW),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rxd       (rxd),
      .dataOut   (dataOut),
      .isNewData (isNewData),
      .frameError(frameError)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (reset) begin
         if (isNewData !== prev_new) begin
            n_toggles++;
            toggle_cyc = cyc;
            rx_q.push_back(dataOut);
         end
         if (frameError) n_ferr++;
      end
      prev_new = isNewData;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rxd = v;
      wait_cycles(CPB);
   endtask

   task automatic send_frame(input logic [BW-1:0] data, input logic stop_bit, input logic par_flip);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < BW; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^data) ^ par_flip);
`else
      if (par_flip) rxd = 1'b1;  // no parity bit in 8N1 frames
`endif
      send_bit(stop_bit);
   endtask

   int t0, f0, q0, lat;

   initial begin
      reset = 1'b0;
      rxd   = 1'b1;
      wait_cycles(5);
      check("rst_data", 32'(dataOut), 32'h0);
      check("rst_new", 32'(isNewData), 32'h0);
      check("rst_ferr", 32'(frameError), 32'h0);
      reset = 1'b1;
      wait_cycles(2 * CPB);

      // Single frame 0x01 and its latency from the start-bit edge.
      send_frame(8'h01, 1'b1, 1'b0);
      wait_cycles(CPB);
      check("f01_toggles", 32'(n_toggles), 32'd1);
      check("f01_new", 32'(isNewData), 32'h1);
      check("f01_data", 32'(dataOut), 32'h01);
      check("f01_ferr", 32'(n_ferr), 32'd0);
      lat = toggle_cyc - start_cyc;
      check("f01_latency", 32'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 32'h1);

      // Back-to-back frames with no idle gap.
      t0 = n_toggles;
      q0 = rx_q.size();
      send_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      wait_cycles(CPB);
      check("b2b_toggles", 32'(n_toggles - t0), 32'd2);
      check("b2b_count", 32'(rx_q.size() - q0), 32'd2);
      check("b2b_first", 32'(rx_q[q0]), 32'hA5);
      check("b2b_second", 32'(rx_q[q0+1]), 32'h3C);
      check("b2b_new", 32'(isNewData), 32'h1);

      // Short low glitch is a false start.
      t0 = n_toggles;
      rxd = 1'b0;
      wait_cycles(4);
      rxd = 1'b1;
      wait_cycles(2 * CPB);
      check("glitch_toggles", 32'(n_toggles - t0), 32'd0);
      check("glitch_data", 32'(dataOut), 32'h3C);
      check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("glitch_ferr", 32'(n_ferr), 32'd0);

      // Bad stop bit followed by a break, then a valid frame.
      t0 = n_toggles;
      send_frame(8'h55, 1'b0, 1'b0);
      rxd = 1'b0;
      wait_cycles(3 * CPB);
      check("brk_ferr", 32'(n_ferr), 32'd1);
      check("brk_no_toggle", 32'(n_toggles - t0), 32'd0);
      check("brk_data", 32'(dataOut), 32'h3C);
      rxd = 1'b1;
      wait_cycles(2 * CPB);
      send_frame(8'h33, 1'b1, 1'b0);
      wait_cycles(CPB);
      check("brk_ferr_once", 32'(n_ferr), 32'd1);
      check("brk_rx_toggles", 32'(n_toggles - t0), 32'd1);
      check("brk_rx_data", 32'(dataOut), 32'h33);

      // Reset in the middle of data bit 4 of 0xFF.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_cycles(CPB / 2);
      reset = 1'b0;
      #1;
      check("mid_rst_data", 32'(dataOut), 32'h0);
      check("mid_rst_new", 32'(isNewData), 32'h0);
      check("mid_rst_ferr", 32'(frameError), 32'h0);
      wait_cycles(5);
      reset = 1'b1;
      wait_cycles(2 * CPB);
      t0 = n_toggles;
      q0 = rx_q.size();
      f0 = n_ferr;
      send_frame(8'h12, 1'b1, 1'b0);
      wait_cycles(CPB);
      check("post_rst_toggles", 32'(n_toggles - t0), 32'd1);
      check("post_rst_first", 32'(rx_q.size() > q0 ? rx_q[q0] : 8'h00), 32'h12);
      check("post_rst_data", 32'(dataOut), 32'h12);
      check("post_rst_new", 32'(isNewData), 32'h1);
      check("post_rst_ferr", 32'(n_ferr - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones, so even parity requires a parity bit of 1.
      t0 = n_toggles;
      f0 = n_ferr;
      send_frame(8'h07, 1'b1, 1'b1);
      wait_cycles(2 * CPB);
      check("par_bad_ferr", 32'(n_ferr - f0), 32'd1);
      check("par_bad_toggle", 32'(n_toggles - t0), 32'd0);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_cycles(CPB);
      check("par_ok_toggle", 32'(n_toggles - t0), 32'd1);
      check("par_ok_data", 32'(dataOut), 32'h07);
      check("par_ok_ferr", 32'(n_ferr - f0), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
